// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers for the
//   EX stage. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. A multiply or divide
//   holds busy high for a fixed number of cycles, then commits to HI/LO and
//   pulses done for one cycle.
//
//   Optional feature macro: MULDIV_MADD_EN
//     When defined, op codes 6=MADD, 7=MADDU, 8=MSUB, 9=MSUBU are accepted.
//     They have multiply latency and accumulate into {hi,lo} at commit.
//     When undefined, codes 6..9 are reserved and ignored like codes 10..15.
//
// Parameters
//   WIDTH        operand and HI/LO width
//   MULT_CYCLES  busy cycles for multiply-class ops (>= 1)
//   DIV_CYCLES   busy cycles for DIV/DIVU (>= 1)
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset; aborts any op in flight
//   start  in   request strobe, honoured only while idle
//   op     in   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6..9 see above)
//   a      in   rs operand
//   b      in   rt operand
//   busy   out  high while a multiply/divide is in flight
//   done   out  one-cycle pulse in the first cycle after a commit
//   hi     out  HI register
//   lo     out  LO register
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OpMult  = 4'd0;
  localparam logic [3:0] OpMultu = 4'd1;
  localparam logic [3:0] OpDiv   = 4'd2;
  localparam logic [3:0] OpDivu  = 4'd3;
  localparam logic [3:0] OpMthi  = 4'd4;
  localparam logic [3:0] OpMtlo  = 4'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd6;
  localparam logic [3:0] OpMaddu = 4'd7;
  localparam logic [3:0] OpMsub  = 4'd8;
  localparam logic [3:0] OpMsubu = 4'd9;
`endif

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {
    Idle = 1'b0,
    Run  = 1'b1
  } stateT;

  stateT            stateReg, stateNext;
  logic [CntW-1:0]  cntReg, cntNext;
  logic [WIDTH-1:0] aReg, bReg;
  logic [3:0]       opReg;
  logic             doneReg;

  logic             isMulOp, isDivOp;
  logic             accept, commit;
  logic             writeMthi, writeMtlo;

  // ---------------------------------------------------------------------------
  // Op classification of the incoming request
  // ---------------------------------------------------------------------------
  always_comb begin
    isMulOp = (op == OpMult) || (op == OpMultu);
`ifdef MULDIV_MADD_EN
    isMulOp = isMulOp || (op == OpMadd) || (op == OpMaddu) ||
              (op == OpMsub) || (op == OpMsubu);
`endif
    isDivOp = (op == OpDiv) || (op == OpDivu);
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    accept    = 1'b0;
    commit    = 1'b0;
    writeMthi = 1'b0;
    writeMtlo = 1'b0;
    case (stateReg)
      Idle: begin
        if (start) begin
          if (isMulOp) begin
            accept    = 1'b1;
            stateNext = Run;
            cntNext   = CntW'(MULT_CYCLES);
          end else if (isDivOp) begin
            accept    = 1'b1;
            stateNext = Run;
            cntNext   = CntW'(DIV_CYCLES);
          end else if (op == OpMthi) begin
            writeMthi = 1'b1;
          end else if (op == OpMtlo) begin
            writeMtlo = 1'b1;
          end
        end
      end
      Run: begin
        // Counter holds the number of busy cycles left including this one.
        cntNext = cntReg - CntW'(1);
        if (cntReg == CntW'(1)) begin
          commit    = 1'b1;
          stateNext = Idle;
        end
      end
      default: stateNext = Idle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arithmetic on the latched operands, evaluated at commit
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prodSigned, prodUnsigned;
  logic               divSigned, aNeg, bNeg;
  logic [WIDTH-1:0]   absA, absB, safeB, quotMag, remMag, quot, rem;
  logic [2*WIDTH-1:0] result;
  logic               resultWrite;

  always_comb begin
    // Sign-extending to 2*WIDTH and keeping the low 2*WIDTH bits of the
    // product gives the exact two's-complement signed product.
    prodSigned   = {{WIDTH{aReg[WIDTH-1]}}, aReg} * {{WIDTH{bReg[WIDTH-1]}}, bReg};
    prodUnsigned = {{WIDTH{1'b0}}, aReg} * {{WIDTH{1'b0}}, bReg};

    // Signed divide is done on magnitudes. For -2^(W-1) / -1 the magnitude
    // quotient is 2^(W-1), which reads back as -2^(W-1) with remainder 0.
    divSigned = (opReg == OpDiv);
    aNeg      = divSigned && aReg[WIDTH-1];
    bNeg      = divSigned && bReg[WIDTH-1];
    absA      = aNeg ? (~aReg + WIDTH'(1)) : aReg;
    absB      = bNeg ? (~bReg + WIDTH'(1)) : bReg;
    // Divide-by-zero never commits; avoid a zero divisor in the datapath.
    safeB     = (absB == '0) ? WIDTH'(1) : absB;
    quotMag   = absA / safeB;
    remMag    = absA % safeB;
    quot      = (aNeg ^ bNeg) ? (~quotMag + WIDTH'(1)) : quotMag;
    rem       = aNeg ? (~remMag + WIDTH'(1)) : remMag;

    result      = {hi, lo};
    resultWrite = 1'b1;
    case (opReg)
      OpMult:  result = prodSigned;
      OpMultu: result = prodUnsigned;
      OpDiv, OpDivu: begin
        result      = {rem, quot};
        resultWrite = (bReg != '0);
      end
`ifdef MULDIV_MADD_EN
      OpMadd:  result = {hi, lo} + prodSigned;
      OpMaddu: result = {hi, lo} + prodUnsigned;
      OpMsub:  result = {hi, lo} - prodSigned;
      OpMsubu: result = {hi, lo} - prodUnsigned;
`endif
      default: resultWrite = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= Idle;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand latches, HI/LO and done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aReg    <= '0;
      bReg    <= '0;
      opReg   <= '0;
      hi      <= '0;
      lo      <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= commit;
      if (accept) begin
        aReg  <= a;
        bReg  <= b;
        opReg <= op;
      end
      if (commit && resultWrite) begin
        {hi, lo} <= result;
      end
      if (writeMthi) hi <= a;
      if (writeMtlo) lo <= a;
    end
  end

  assign busy = (stateReg == Run);
  assign done = doneReg;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expLen;
  } resT;

  typedef struct {
    string       name;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expBusy;
    logic        expDone;
  } snapT;

  resT  resQ[$];
  snapT snapQ[$];
  logic sampleReq = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   busyRun = 0;
  int   waitCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: snapshots on request, result records on every done pulse.
  always @(negedge clk) begin
    if (sampleReq && snapQ.size() != 0) begin
      snapT s;
      s = snapQ.pop_front();
      chk({s.name, ".hi"}, hi, s.expHi);
      chk({s.name, ".lo"}, lo, s.expLo);
      chk({s.name, ".busy"}, {31'd0, busy}, {31'd0, s.expBusy});
      chk({s.name, ".done"}, {31'd0, done}, {31'd0, s.expDone});
    end
    if (done) begin
      if (resQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        resT r;
        r = resQ.pop_front();
        chk({r.name, ".hi"}, hi, r.expHi);
        chk({r.name, ".lo"}, lo, r.expLo);
        chk({r.name, ".busyCycles"}, busyRun, r.expLen);
      end
      waitCnt = 0;
    end else if (resQ.size() != 0) begin
      waitCnt++;
      if (waitCnt > 40) begin
        resT r;
        r = resQ.pop_front();
        checks++;
        errors++;
        $display("FAIL %s.timeout: got no done within 40 cycles expected done", r.name);
        waitCnt = 0;
      end
    end
    busyRun = busy ? busyRun + 1 : 0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the request is sampled at the next rising edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step(1);
    start = 1'b0; op = 4'd15; a = '0; b = '0;
  endtask

  task automatic expectRes(input string n, input logic [31:0] h, input logic [31:0] l, input int len);
    resT r;
    r.name = n; r.expHi = h; r.expLo = l; r.expLen = len;
    resQ.push_back(r);
  endtask

  task automatic snap(input string n, input logic [31:0] h, input logic [31:0] l,
                      input logic bz, input logic dn);
    snapT s;
    s.name = n; s.expHi = h; s.expLo = l; s.expBusy = bz; s.expDone = dn;
    snapQ.push_back(s);
    sampleReq = 1'b1;
    step(1);
    sampleReq = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 60; i++) begin
      if (resQ.size() == 0) break;
      step(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd15; a = '0; b = '0;
    step(2);
    snap("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1);

    // Reset mid-op: MTHI, then MULT aborted in cycle T+2
    issue(4'd4, 32'h1234, 32'h0);
    snap("mthi", 32'h1234, 32'h0, 1'b0, 1'b0);
    issue(4'd0, 32'd3, 32'd4);      // returns in T+1
    step(1);                        // T+2
    reset = 1'b1;
    #2;
    snap("reset_mid", 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(12);
    snap("no_commit", 32'h0, 32'h0, 1'b0, 1'b0);

    // Signed multiply
    expectRes("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    issue(4'd0, 32'hFFFFFFFF, 32'h2);
    snap("mult_busy", 32'h0, 32'h0, 1'b1, 1'b0);
    waitDone();
    snap("done_clear", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);

    // Unsigned full-width multiply
    expectRes("multu_max", 32'hFFFFFFFE, 32'h00000001, 5);
    issue(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone();

    // Divides
    expectRes("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(4'd2, 32'hFFFFFFF9, 32'd2);
    waitDone();
    expectRes("divu", 32'd1, 32'd3, 10);
    issue(4'd3, 32'd7, 32'd2);
    waitDone();
    expectRes("div_ovf", 32'h0, 32'h80000000, 10);
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    waitDone();

    // Divide by zero leaves HI/LO untouched
    issue(4'd4, 32'hAA, 32'h0);
    issue(4'd5, 32'h55, 32'h0);
    expectRes("divu_zero", 32'hAA, 32'h55, 10);
    issue(4'd3, 32'd9, 32'd0);
    waitDone();

    // start while busy is ignored
    expectRes("multu_ign", 32'h0, 32'd6, 5);
    issue(4'd1, 32'd2, 32'd3);      // returns in T+1
    step(1);                        // T+2
    issue(4'd5, 32'h99, 32'h0);
    waitDone();
    issue(4'd5, 32'h99, 32'h0);
    snap("mtlo_after", 32'h0, 32'h99, 1'b0, 1'b0);

    // Back-to-back: new op issued in the done cycle
    expectRes("b2b_mul", 32'h0, 32'h100, 5);
    expectRes("b2b_div", 32'd2, 32'd14, 10);
    issue(4'd1, 32'h10, 32'h10);    // returns in T+1
    step(5);                        // T+6, done cycle
    issue(4'd3, 32'd100, 32'd7);
    waitDone();

    // Reserved op is ignored
    issue(4'd12, 32'h1, 32'h1);
    snap("reserved", 32'd2, 32'd14, 1'b0, 1'b0);

`ifdef MULDIV_MADD_EN
    issue(4'd4, 32'h0, 32'h0);
    issue(4'd5, 32'hFFFFFFFF, 32'h0);
    expectRes("maddu", 32'd1, 32'h0, 5);
    issue(4'd7, 32'd1, 32'd1);
    waitDone();
    expectRes("msub", 32'h0, 32'hFFFFFFFF, 5);
    issue(4'd8, 32'd1, 32'd1);
    waitDone();
`else
    issue(4'd6, 32'd1, 32'd1);
    snap("madd_off", 32'd2, 32'd14, 1'b0, 1'b0);
`endif

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
